// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci LED sequencer.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int unsigned FIB_INIT0 = 1;
  localparam int unsigned FIB_INIT1 = 1;

  // Number of low prescaler bits that must all be ones for a tick; never negative.
  function automatic int prescale_bits(input int div_w, input logic [1:0] speed);
    int k;
    k = div_w - 2 * int'({30'd0, speed});
    return (k < 0) ? 0 : k;
  endfunction

endpackage

// File: rtl/fib_datapath.sv
// Fibonacci pair register {num, num2} with overflow latch-back and wrap restart.
import fib_seq_pkg::*;

module fib_datapath #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         reload,
  input  logic         wrap,
  output logic [W-1:0] num,
  output logic         last,
  output logic         carry
);

  logic [W-1:0] num2;
  logic [W:0]   sum;

  assign sum   = {1'b0, num} + {1'b0, num2};
  assign carry = sum[W];

  // On carry num catches up to num2 so the final in-range value is shown once.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      num  <= W'(FIB_INIT0);
      num2 <= W'(FIB_INIT1);
      last <= 1'b0;
    end else if (advance) begin
      if (last) begin
        num  <= W'(FIB_INIT0);
        num2 <= W'(FIB_INIT1);
        last <= 1'b0;
      end else if (carry) begin
        num  <= num2;
        last <= wrap;
      end else begin
        num  <= num2;
        num2 <= sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Run/pause/step controller with prescaler around the Fibonacci datapath.
import fib_seq_pkg::*;

module fib_sequencer #(
  parameter int unsigned W     = 8,
  parameter int unsigned DIV_W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         step,
  input  logic [1:0]   speed,
  input  logic         wrap,
  output logic [W-1:0] num,
  output logic         num_valid,
  output logic         overflow,
  output logic [1:0]   state
);

  state_t           cur_state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] tick_mask;
  int               shift_c;
  logic             tick_c;
  logic             advance_c;
  logic             reload_c;
  logic             clear_cnt_c;
  logic             ovf_c;
  logic             halt_c;
  logic             last;
  logic             carry;

  assign state = cur_state;

  // Tick when the low k counter bits are all ones; k=0 ticks every cycle.
  always_comb begin
    shift_c   = prescale_bits(int'(DIV_W), speed);
    tick_mask = '0;
    for (int i = 0; i < int'(DIV_W); i++) begin
      tick_mask[i] = (i < shift_c);
    end
  end

  assign tick_c = &(cnt | ~tick_mask);

  // Event decode: pause beats tick in RUN, start beats step in PAUSED.
  always_comb begin
    advance_c   = ((cur_state == RUN) && !pause && tick_c) ||
                  ((cur_state == PAUSED) && !start && step);
    reload_c    = (cur_state == HALT) && start;
    clear_cnt_c = start && (cur_state != RUN);
    ovf_c       = advance_c && carry && !last;
    halt_c      = ovf_c && !wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      cnt       <= '0;
      num_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      num_valid <= advance_c;

      if (clear_cnt_c) begin
        cnt <= '0;
      end else if (cur_state == RUN) begin
        cnt <= cnt + DIV_W'(1);
      end

      if (reload_c) begin
        overflow <= 1'b0;
      end else if (ovf_c) begin
        overflow <= 1'b1;
      end

      case (cur_state)
        IDLE: begin
          if (start) cur_state <= RUN;
        end
        RUN: begin
          if (pause)       cur_state <= PAUSED;
          else if (halt_c) cur_state <= HALT;
        end
        PAUSED: begin
          if (start)       cur_state <= RUN;
          else if (halt_c) cur_state <= HALT;
        end
        HALT: begin
          if (start) cur_state <= RUN;
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

  fib_datapath #(
    .W(W)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .advance(advance_c),
    .reload (reload_c),
    .wrap   (wrap),
    .num    (num),
    .last   (last),
    .carry  (carry)
  );

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Run/pause/step controller wrapped around the 8-bit Fibonacci datapath that drives the board LEDs. It owns the step prescaler and sequences the `{num, num2}` pair. It detects 8-bit overflow and then either halts or restarts the sequence. Upstream are debounced, single-cycle button pulses; downstream, `num` goes to the LED inversion stage.

## Interface

- `W`, default 8: Fibonacci operand width.
- `DIV_W`, default 25: prescaler counter width; use 4 in simulation.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that starts or resumes the sequence.
- `pause`, in, 1: one-cycle pulse that pauses the sequence.
- `step`, in, 1: one-cycle pulse that advances once while paused.
- `speed`, in, 2: selects the prescaler rate; 0 is slowest.
- `wrap`, in, 1: 1 restarts the sequence after overflow; 0 halts on overflow.
- `num`, out, W: currently displayed Fibonacci value.
- `num_valid`, out, 1: one-cycle pulse; high in the first cycle `num` holds a new value.
- `overflow`, out, 1: sticky flag; set when the next sum exceeds W bits.
- `state`, out, 2: current state, encoded IDLE=0, RUN=1, PAUSED=2, HALT=3.

## Operation

Datapath:
- Registers are `num`, `num2` (both W bits) and `last` (1 bit).
- Reset and reload value: `{num,num2}={1,1}`, `last=0`.
- Advance with `last=1`: load `{1,1}`, clear `last`.
- Advance with no carry: `{num,num2} <= {num2, num+num2}`.
- Advance where `num+num2` carries out of W bits:
  - `num <= num2`, `num2` holds.
  - `overflow <= 1`.
  - If `wrap=1`: set `last=1`.
  - If `wrap=0`: go to HALT.
- Every advance pulses `num_valid` in the cycle the new `num` is visible.
- For W=8, `num` runs 1,1,2,…,144,233; then either HALT at 233, or continue 1,1,2,… in wrap mode.

State machine (one event is acted on per cycle; priority start > pause > step > tick):
- IDLE:
  - `start` → RUN, clear the prescaler.
  - Everything else is ignored.
- RUN:
  - `tick` → advance.
  - `pause` → PAUSED; no advance that cycle, even if tick is high.
  - `start` and `step` are ignored.
- PAUSED:
  - `start` → RUN, clear the prescaler.
  - `step` → one advance, stay PAUSED (HALT instead if the advance overflows with `wrap=0`).
- HALT:
  - `start` → reload `{1,1}`, clear `overflow` and `last`, clear the prescaler, go to RUN.
  - Everything else is ignored.
- `rst` in any state: IDLE, all registers to reset values. This also applies mid-advance; `rst` wins over every other input.

Prescaler:
- `cnt` is DIV_W bits; it increments only in RUN and wraps naturally.
- k = max(DIV_W − 2·speed, 0).
- `tick` = low k bits of `cnt` all ones; k=0 gives a tick every RUN cycle.
- A `speed` change takes effect on the next cycle without clearing `cnt`.

## Timing

Reset values:
- `num=1`, `num_valid=0`, `overflow=0`, `state=IDLE`, `cnt=0`.

Latencies:
- Input pulse to state change: 1 cycle (registered).
- First advance after entering RUN: 2^k cycles after the `start` edge, i.e. `num_valid` high in cycle 2^k+1.
- `step` in PAUSED: `num_valid` and the new `num` appear the next cycle.
- Overflow with `wrap=0`: `overflow`, `state=HALT` and `num=233` all appear in the same cycle.

Other rules:
- No combinational path from inputs to outputs.
- Simultaneous `pause` and `tick` in RUN: pause wins, and the tick is lost.

## Structure

Package `fib_seq_pkg`:
- `state_t` enum (IDLE, RUN, PAUSED, HALT).
- Reload constants `FIB_INIT0`/`FIB_INIT1` = 1.

Sub-module `fib_datapath`:
- Holds `num`, `num2` and `last`.
- Inputs `advance` and `reload`; outputs `num` and a combinational `carry` (carry of `num+num2`).
- The top level contains the FSM, the prescaler and the output registering.

## Test plan

All scenarios use DIV_W=4, W=8.

- **Reset and RUN spacing:** reset, `start`, `speed=0` → `state=RUN`; `num_valid` pulses every 16 cycles, giving `num` = 1,2,3,5,8.
- **Fast rate:** `speed=2` (k=0) → a `num_valid` pulse every cycle; `num` reaches 233 in 12 advances.
- **Halt on overflow:** `wrap=0` → HALT with `num=233`, `overflow=1` and no further pulses. Then `start` → `num=1`, `overflow=0`, `state=RUN`.
- **Wrap on overflow:** `wrap=1` → sequence …,144,233,1,1,2; `overflow` stays high, `state` stays RUN.
- **Pause and step:** `pause` on a tick cycle → no advance, `state=PAUSED`. Each of three `step` pulses gives exactly one `num_valid` pulse the next cycle. `start` → RUN, with the next advance 16 cycles later.
- **Mid-run reset:** `rst` during RUN with `num=34` → next cycle `num=1`, `state=IDLE`, `overflow=0`; `step` and `pause` are then ignored.
